// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx between NUM_REQ byte-stream requesters.
// A grant lasts for a whole message, capped by MAX_MSG_LEN and revoked after IDLE_TIMEOUT idle cycles.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int MAX_MSG_LEN  = 16,
  parameter int IDLE_TIMEOUT = 1024
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [NUM_REQ-1:0]   i_req_valid,
  input  logic [8*NUM_REQ-1:0] i_req_data,
  input  logic [NUM_REQ-1:0]   i_req_last,
  output logic [NUM_REQ-1:0]   o_req_ready,
  output logic [7:0]           o_tx_data,
  output logic                 o_tx_valid,
  input  logic                 i_tx_rdy,
  output logic [NUM_REQ-1:0]   o_grant,
  output logic                 o_busy,
  output logic                 o_trunc,
  output logic                 o_timeout
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int BW = (MAX_MSG_LEN > 0) ? $clog2(MAX_MSG_LEN + 1) : 1;
  localparam int TW = (IDLE_TIMEOUT > 0) ? $clog2(IDLE_TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    S_ARB,
    S_FETCH,
    S_SEND
  } state_t;

  state_t             state;
  logic [IW-1:0]      last_grant;
  logic [IW-1:0]      grant_idx;
  logic [BW-1:0]      byte_cnt;
  logic [TW-1:0]      idle_cnt;
  logic               last_flag;

  logic               arb_found;
  logic [IW-1:0]      arb_idx;
  logic [IW-1:0]      cand_idx;
  logic [NUM_REQ-1:0] arb_onehot;
  logic [7:0]         sel_data;
  logic               sel_last;
  logic               sel_valid;
  logic               tx_xfer;

  // Search upward from the previous owner so every requester gets a turn.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    cand_idx  = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand_idx = IW'((int'(last_grant) + i) % NUM_REQ);
      if (!arb_found && i_req_valid[cand_idx]) begin
        arb_found = 1'b1;
        arb_idx   = cand_idx;
      end
    end
  end

  assign arb_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << arb_idx;

  always_comb begin
    sel_data = '0;
    sel_last = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant_idx == IW'(k)) begin
        sel_data = i_req_data[8*k +: 8];
        sel_last = i_req_last[k];
      end
    end
  end

  assign o_req_ready = (state == S_FETCH) ? o_grant : '0;
  assign sel_valid   = |(i_req_valid & o_req_ready);
  assign tx_xfer     = o_tx_valid & i_tx_rdy;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= S_ARB;
      last_grant <= IW'(NUM_REQ - 1);
      grant_idx  <= '0;
      byte_cnt   <= '0;
      idle_cnt   <= '0;
      last_flag  <= 1'b0;
      o_tx_data  <= '0;
      o_tx_valid <= 1'b0;
      o_grant    <= '0;
      o_busy     <= 1'b0;
      o_trunc    <= 1'b0;
      o_timeout  <= 1'b0;
    end else begin
      o_trunc   <= 1'b0;
      o_timeout <= 1'b0;
      case (state)
        S_ARB: begin
          if (arb_found) begin
            grant_idx <= arb_idx;
            o_grant   <= arb_onehot;
            o_busy    <= 1'b1;
            byte_cnt  <= '0;
            idle_cnt  <= '0;
            state     <= S_FETCH;
          end
        end

        S_FETCH: begin
          if (sel_valid) begin
            o_tx_data  <= sel_data;
            o_tx_valid <= 1'b1;
            last_flag  <= sel_last;
            // Saturate so an unlimited message length never wraps the count.
            if (byte_cnt != {BW{1'b1}}) begin
              byte_cnt <= byte_cnt + 1'b1;
            end
            idle_cnt   <= '0;
            state      <= S_SEND;
          end else if ((IDLE_TIMEOUT != 0) && (idle_cnt == TW'(IDLE_TIMEOUT - 1))) begin
            o_timeout  <= 1'b1;
            last_grant <= grant_idx;
            o_grant    <= '0;
            o_busy     <= 1'b0;
            state      <= S_ARB;
          end else if (idle_cnt != {TW{1'b1}}) begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end

        S_SEND: begin
          if (tx_xfer) begin
            o_tx_valid <= 1'b0;
            if (last_flag) begin
              last_grant <= grant_idx;
              o_grant    <= '0;
              o_busy     <= 1'b0;
              state      <= S_ARB;
            end else if ((MAX_MSG_LEN != 0) && (byte_cnt == BW'(MAX_MSG_LEN))) begin
              o_trunc    <= 1'b1;
              last_grant <= grant_idx;
              o_grant    <= '0;
              o_busy     <= 1'b0;
              state      <= S_ARB;
            end else begin
              state <= S_FETCH;
            end
          end
        end

        default: state <= S_ARB;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: requester queues and a uart_tx model drive the DUT,
// and every byte reaching the UART is checked against a scoreboard of expected bytes and owners.
module tb_uart_tx_arbiter;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic [7:0]     tx_data;
  logic           tx_valid;
  logic           tx_rdy;
  logic [N-1:0]   grant;
  logic           busy;
  logic           trunc;
  logic           timeout;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NUM_REQ(N),
    .MAX_MSG_LEN(4),
    .IDLE_TIMEOUT(8)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_req_valid(req_valid),
    .i_req_data(req_data),
    .i_req_last(req_last),
    .o_req_ready(req_ready),
    .o_tx_data(tx_data),
    .o_tx_valid(tx_valid),
    .i_tx_rdy(tx_rdy),
    .o_grant(grant),
    .o_busy(busy),
    .o_trunc(trunc),
    .o_timeout(timeout)
  );

  typedef struct packed {
    logic [7:0]   data;
    logic [N-1:0] owner;
  } exp_t;

  int         checks = 0;
  int         errors = 0;
  exp_t       sb[$];
  logic [8:0] rmem[N][16];
  int         rhead[N];
  int         rtail[N];
  logic [N-1:0] en;
  int         uart_delay;
  int         uart_wait;
  int         n_trunc;
  int         n_timeout;
  logic       hold2;
  logic       last_xfer;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic pushByte(input int k, input logic [7:0] d, input logic last);
    rmem[k][rtail[k]] = {last, d};
    rtail[k]++;
  endtask

  task automatic expectByte(input logic [7:0] d, input int k);
    exp_t e;
    e.data  = d;
    e.owner = N'(1) << k;
    sb.push_back(e);
  endtask

  // One clock cycle: drive requesters and the UART model, then score what the DUT shows.
  task automatic applyStimulus();
    exp_t e;
    @(negedge clk);
    for (int k = 0; k < N; k++) begin
      if (en[k] && (rhead[k] < rtail[k])) begin
        req_valid[k]       = 1'b1;
        req_data[8*k +: 8] = rmem[k][rhead[k]][7:0];
        req_last[k]        = rmem[k][rhead[k]][8];
      end else begin
        req_valid[k]       = 1'b0;
        req_data[8*k +: 8] = 8'h00;
        req_last[k]        = 1'b0;
      end
    end
    if (tx_valid) begin
      if (uart_wait == 0) begin
        tx_rdy = 1'b1;
      end else begin
        tx_rdy = 1'b0;
        uart_wait--;
      end
    end else begin
      tx_rdy = 1'b0;
    end
    #1;
    checkOutput("ready_onehot0", 32'($countones(req_ready) <= 1), 1);
    if (hold2) checkOutput("ready2_held_low", req_ready[2], 0);
    if (trunc) n_trunc++;
    if (timeout) n_timeout++;
    for (int k = 0; k < N; k++) begin
      if (req_valid[k] && req_ready[k]) rhead[k]++;
    end
    last_xfer = 1'b0;
    if (tx_valid && tx_rdy) begin
      last_xfer = 1'b1;
      uart_wait = uart_delay;
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("[TB] FAIL unexpected_byte: observed 0x%0h expected no transfer", tx_data);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        checkOutput("tx_data", tx_data, e.data);
        checkOutput("tx_owner", grant, e.owner);
      end
    end
  endtask

  task automatic applyReset();
    @(negedge clk);
    rst       = 1'b1;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    tx_rdy    = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < N; k++) begin
      rhead[k] = 0;
      rtail[k] = 0;
    end
    sb.delete();
    en        = '1;
    hold2     = 1'b0;
    uart_wait = uart_delay;
    n_trunc   = 0;
    n_timeout = 0;
  endtask

  task automatic runUntilIdle(input string tag, input int limit);
    logic done;
    done = 1'b0;
    for (int i = 0; i < limit && !done; i++) begin
      applyStimulus();
      if (sb.size() == 0 && !busy) done = 1'b1;
    end
    checkOutput({tag, "_drained"}, done, 1);
  endtask

  initial begin
    int   nx;
    int   first_to;
    logic fell;
    logic flag;
    logic chk_next;
    logic [N-1:0] grant_at_to;

    rst        = 1'b1;
    req_valid  = '0;
    req_data   = '0;
    req_last   = '0;
    tx_rdy     = 1'b0;
    uart_delay = 5;
    last_xfer  = 1'b0;
    applyReset();

    checkOutput("rst_tx_valid", tx_valid, 0);
    checkOutput("rst_tx_data", tx_data, 0);
    checkOutput("rst_grant", grant, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_trunc", trunc, 0);
    checkOutput("rst_timeout", timeout, 0);
    checkOutput("rst_ready", req_ready, 0);

    $display("[TB] single requester, slow uart");
    pushByte(1, 8'h41, 1'b0);
    pushByte(1, 8'h42, 1'b0);
    pushByte(1, 8'h43, 1'b1);
    expectByte(8'h41, 1);
    expectByte(8'h42, 1);
    expectByte(8'h43, 1);
    nx   = 0;
    fell = 1'b0;
    for (int i = 0; i < 200 && !fell; i++) begin
      applyStimulus();
      if (nx == 3) begin
        checkOutput("t1_busy_fall", busy, 0);
        fell = 1'b1;
      end else begin
        if (busy) checkOutput("t1_grant", grant, 4'b0010);
        if (last_xfer) begin
          nx++;
          if (nx == 3) checkOutput("t1_busy_at_last", busy, 1);
        end
      end
    end
    checkOutput("t1_done", fell, 1);
    checkOutput("t1_sb_empty", sb.size(), 0);

    $display("[TB] round robin from reset");
    uart_delay = 1;
    applyReset();
    pushByte(0, 8'hA0, 1'b1);
    pushByte(0, 8'hA4, 1'b1);
    pushByte(1, 8'hA1, 1'b1);
    pushByte(2, 8'hA2, 1'b1);
    pushByte(3, 8'hA3, 1'b1);
    expectByte(8'hA0, 0);
    expectByte(8'hA1, 1);
    expectByte(8'hA2, 2);
    expectByte(8'hA3, 3);
    expectByte(8'hA4, 0);
    runUntilIdle("t2", 300);

    $display("[TB] message atomicity");
    applyReset();
    en[2] = 1'b0;
    hold2 = 1'b1;
    pushByte(0, 8'hB0, 1'b0);
    pushByte(0, 8'hB1, 1'b0);
    pushByte(0, 8'hB2, 1'b1);
    pushByte(2, 8'hC0, 1'b0);
    pushByte(2, 8'hC1, 1'b1);
    expectByte(8'hB0, 0);
    expectByte(8'hB1, 0);
    expectByte(8'hB2, 0);
    expectByte(8'hC0, 2);
    expectByte(8'hC1, 2);
    for (int i = 0; i < 50 && rhead[0] == 0; i++) applyStimulus();
    checkOutput("t3_first_fetch", rhead[0] != 0, 1);
    en[2] = 1'b1;
    for (int i = 0; i < 200 && hold2; i++) begin
      applyStimulus();
      if (last_xfer && sb.size() == 2) hold2 = 1'b0;
    end
    checkOutput("t3_msg0_done", hold2, 0);
    runUntilIdle("t3", 200);

    $display("[TB] truncation at four bytes");
    applyReset();
    for (int b = 1; b <= 6; b++) pushByte(3, 8'hD0 + 8'(b), b == 6);
    for (int b = 1; b <= 4; b++) expectByte(8'hD0 + 8'(b), 3);
    flag = 1'b0;
    for (int i = 0; i < 50 && !flag; i++) begin
      applyStimulus();
      if (busy && grant == 4'b1000) flag = 1'b1;
    end
    checkOutput("t4_grant3", flag, 1);
    pushByte(0, 8'hE0, 1'b1);
    expectByte(8'hE0, 0);
    expectByte(8'hD5, 3);
    expectByte(8'hD6, 3);
    nx       = 0;
    chk_next = 1'b0;
    flag     = 1'b0;
    for (int i = 0; i < 400 && !flag; i++) begin
      applyStimulus();
      if (chk_next) begin
        checkOutput("t4_trunc_pulse", trunc, 1);
        chk_next = 1'b0;
      end
      if (last_xfer) begin
        nx++;
        if (nx == 4) chk_next = 1'b1;
      end
      if (sb.size() == 0 && !busy) flag = 1'b1;
    end
    checkOutput("t4_drained", flag, 1);
    checkOutput("t4_trunc_count", n_trunc, 1);

    $display("[TB] idle timeout");
    uart_delay = 2;
    applyReset();
    pushByte(1, 8'hF0, 1'b0);
    expectByte(8'hF0, 1);
    flag = 1'b0;
    for (int i = 0; i < 50 && !flag; i++) begin
      applyStimulus();
      if (last_xfer) flag = 1'b1;
    end
    checkOutput("t5_byte_sent", flag, 1);
    first_to    = 0;
    grant_at_to = '1;
    for (int s = 1; s <= 12; s++) begin
      applyStimulus();
      if (timeout && first_to == 0) begin
        first_to    = s;
        grant_at_to = grant;
      end
    end
    checkOutput("t5_timeout_cycle", first_to, 9);
    checkOutput("t5_grant_cleared", grant_at_to, 0);
    checkOutput("t5_timeout_count", n_timeout, 1);
    pushByte(0, 8'h60, 1'b1);
    pushByte(2, 8'h62, 1'b1);
    pushByte(3, 8'h63, 1'b1);
    expectByte(8'h62, 2);
    expectByte(8'h63, 3);
    expectByte(8'h60, 0);
    runUntilIdle("t5", 200);

    $display("[TB] reset during send");
    uart_delay = 20;
    uart_wait  = 20;
    pushByte(1, 8'h71, 1'b1);
    expectByte(8'h71, 1);
    flag = 1'b0;
    for (int i = 0; i < 20 && !flag; i++) begin
      applyStimulus();
      if (tx_valid && !tx_rdy) flag = 1'b1;
    end
    checkOutput("t6_sending", flag, 1);
    uart_delay = 1;
    applyReset();
    checkOutput("t6_tx_valid", tx_valid, 0);
    checkOutput("t6_tx_data", tx_data, 0);
    checkOutput("t6_grant", grant, 0);
    checkOutput("t6_busy", busy, 0);
    pushByte(1, 8'h81, 1'b1);
    pushByte(0, 8'h80, 1'b1);
    expectByte(8'h80, 0);
    expectByte(8'h81, 1);
    runUntilIdle("t6", 200);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
